// File: rtl/updown_counter_ctrl.sv
// updown_counter_ctrl: button-controlled up/down counter with an internal
// prescaler that produces a single-domain clock enable (tick).
// Buttons: btn_dir toggles direction, btn_run toggles run/pause, btn_clr
// clears the count. Each button is 2-FF synchronised and rising-edge detected.
// SATURATE selects wrap (0) or hold-at-limit (1) behaviour.
// Optional macro DEBOUNCE_EN inserts a per-button debouncer of
// DEBOUNCE_CYCLES stable cycles between the synchroniser and the edge detector.
module updown_counter_ctrl #(
  parameter int WIDTH           = 4,
  parameter int PRESCALE        = 16777216,
  parameter int SATURATE        = 0,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_dir,
  input  logic             btn_run,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             run,
  output logic             tick,
  output logic             limit
);

  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // Reject nonsensical parameter sets at elaboration time.
  if (WIDTH < 1 || PRESCALE < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("updown_counter_ctrl: illegal parameter value");
  end

  // Button bit order: [0]=dir, [1]=run, [2]=clr.
  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] level;
  logic [2:0] prev;
  logic [2:0] press;

  logic [PS_W-1:0] presc;

  assign btn_raw = {btn_clr, btn_run, btn_dir};

  // Two-flop synchroniser for the asynchronous pushbuttons.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt [3];
  logic [2:0]      db_level;

  // Debouncer: level follows the input only after DEBOUNCE_CYCLES consecutive
  // differing samples; any return to the current level restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_level <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] != db_level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_level[i] <= sync2[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign level = db_level;
`else
  assign level = sync2;
`endif

  // Edge-detect history; a held button yields exactly one press pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= level;
    end
  end

  assign press = level & ~prev;

  // Control state, prescaler and counter. Steps use the pre-edge dir/run so a
  // coincident press only affects later steps; clr overrides any step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      dir   <= 1'b0;
      run   <= 1'b1;
      tick  <= 1'b0;
      limit <= 1'b0;
      presc <= '0;
    end else begin
      tick  <= 1'b0;
      limit <= 1'b0;
      if (press[0]) begin
        dir <= ~dir;
      end
      if (press[1]) begin
        run <= ~run;
      end
      if (press[2]) begin
        count <= '0;
        presc <= '0;
      end else if (run) begin
        if (presc == PS_LAST) begin
          presc <= '0;
          tick  <= 1'b1;
          if (dir) begin
            if (count == '1) begin
              limit <= 1'b1;
              if (SATURATE == 0) begin
                count <= '0;
              end
            end else begin
              count <= count + WIDTH'(1);
            end
          end else begin
            if (count == '0) begin
              limit <= 1'b1;
              if (SATURATE == 0) begin
                count <= '1;
              end
            end else begin
              count <= count - WIDTH'(1);
            end
          end
        end else begin
          presc <= presc + PS_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Testbench for updown_counter_ctrl: a wrap instance and a saturate instance
// share clock, reset and buttons. Constant vector table, hand-written corner
// sequences, then random buttons/reset against a behavioural model.
module tb_updown_counter_ctrl;

  localparam int W    = 4;
  localparam int P    = 4;
  localparam int MAXV = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_dir = 1'b0;
  logic btn_run = 1'b0;
  logic btn_clr = 1'b0;

  logic [W-1:0] count_w, count_s;
  logic dir_w, run_w, tick_w, limit_w;
  logic dir_s, run_s, tick_s, limit_s;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  updown_counter_ctrl #(.WIDTH(W), .PRESCALE(P), .SATURATE(0), .DEBOUNCE_CYCLES(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .btn_dir(btn_dir), .btn_run(btn_run), .btn_clr(btn_clr),
    .count(count_w), .dir(dir_w), .run(run_w), .tick(tick_w), .limit(limit_w)
  );

  updown_counter_ctrl #(.WIDTH(W), .PRESCALE(P), .SATURATE(1), .DEBOUNCE_CYCLES(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .btn_dir(btn_dir), .btn_run(btn_run), .btn_clr(btn_clr),
    .count(count_s), .dir(dir_s), .run(run_s), .tick(tick_s), .limit(limit_s)
  );

  // Behavioural model state
  int m_cw, m_cs, m_ph;
  bit m_dir, m_run, m_tick, m_lw, m_ls;
  bit q_dir[$];
  bit q_run[$];
  bit q_clr[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endfunction

  // A press takes effect at edge k when the button was sampled high at edge
  // k-2 and low at edge k-3 (samples before reset count as low).
  function automatic bit press_of(input bit q[$]);
    int n;
    n = q.size();
    if (n < 2) return 1'b0;
    if (!q[n-2]) return 1'b0;
    if (n < 3) return 1'b1;
    return !q[n-3];
  endfunction

  task automatic model_edge();
    bit pd, pr, pc;
    if (!rst_n) begin
      m_cw = 0; m_cs = 0; m_ph = 0;
      m_dir = 1'b0; m_run = 1'b1; m_tick = 1'b0; m_lw = 1'b0; m_ls = 1'b0;
      q_dir.delete(); q_run.delete(); q_clr.delete();
    end else begin
      pd = press_of(q_dir);
      pr = press_of(q_run);
      pc = press_of(q_clr);
      m_tick = 1'b0; m_lw = 1'b0; m_ls = 1'b0;
      if (pc) begin
        m_cw = 0; m_cs = 0; m_ph = 0;
      end else if (m_run) begin
        if (m_ph == P - 1) begin
          m_ph = 0;
          m_tick = 1'b1;
          if (m_dir) begin
            m_lw = (m_cw == MAXV);
            m_cw = (m_cw + 1) % (MAXV + 1);
            if (m_cs == MAXV) m_ls = 1'b1; else m_cs = m_cs + 1;
          end else begin
            m_lw = (m_cw == 0);
            m_cw = (m_cw + MAXV) % (MAXV + 1);
            if (m_cs == 0) m_ls = 1'b1; else m_cs = m_cs - 1;
          end
        end else begin
          m_ph = m_ph + 1;
        end
      end
      if (pd) m_dir = !m_dir;
      if (pr) m_run = !m_run;
      q_dir.push_back(btn_dir);
      q_run.push_back(btn_run);
      q_clr.push_back(btn_clr);
      while (q_dir.size() > 3) void'(q_dir.pop_front());
      while (q_run.size() > 3) void'(q_run.pop_front());
      while (q_clr.size() > 3) void'(q_clr.pop_front());
    end
  endtask

  task automatic compare_model();
    chk("m_count_wrap", 32'(count_w), 32'(m_cw));
    chk("m_count_sat", 32'(count_s), 32'(m_cs));
    chk("m_dir_wrap", 32'(dir_w), 32'(m_dir));
    chk("m_dir_sat", 32'(dir_s), 32'(m_dir));
    chk("m_run_wrap", 32'(run_w), 32'(m_run));
    chk("m_run_sat", 32'(run_s), 32'(m_run));
    chk("m_tick_wrap", 32'(tick_w), 32'(m_tick));
    chk("m_tick_sat", 32'(tick_s), 32'(m_tick));
    chk("m_limit_wrap", 32'(limit_w), 32'(m_lw));
    chk("m_limit_sat", 32'(limit_s), 32'(m_ls));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit bd, br, bc;
    int n;
    int cw, cs;
    bit d, r, t, lw, ls;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // edges counted from the last reset edge; steps land on edges 4,8,...
    vecs[0]  = '{0, 0, 0,  4, 15, 0, 0, 1, 1, 1, 1};
    vecs[1]  = '{0, 0, 0,  4, 14, 0, 0, 1, 1, 0, 1};
    vecs[2]  = '{1, 0, 0,  3, 14, 0, 1, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 0,  1, 15, 1, 1, 1, 1, 0, 0};
    vecs[4]  = '{0, 0, 0,  4,  0, 2, 1, 1, 1, 1, 0};
    vecs[5]  = '{0, 0, 1,  3,  0, 0, 1, 1, 0, 0, 0};
    vecs[6]  = '{0, 0, 0,  4,  1, 1, 1, 1, 1, 0, 0};
    vecs[7]  = '{0, 1, 0,  3,  1, 1, 1, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 20,  1, 1, 1, 0, 0, 0, 0};
    vecs[9]  = '{0, 1, 0,  3,  1, 1, 1, 1, 0, 0, 0};
    vecs[10] = '{0, 0, 0,  1,  2, 2, 1, 1, 1, 0, 0};

    // Reset values
    do_reset();
    chk("rst_count_wrap", 32'(count_w), 32'd0);
    chk("rst_count_sat", 32'(count_s), 32'd0);
    chk("rst_dir", 32'(dir_w), 32'd0);
    chk("rst_run", 32'(run_w), 32'd1);
    chk("rst_tick", 32'(tick_w), 32'd0);
    chk("rst_limit", 32'(limit_w), 32'd0);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      btn_dir = vecs[i].bd;
      btn_run = vecs[i].br;
      btn_clr = vecs[i].bc;
      repeat (vecs[i].n) cyc();
      chk($sformatf("vec%0d_count_wrap", i), 32'(count_w), 32'(vecs[i].cw));
      chk($sformatf("vec%0d_count_sat", i), 32'(count_s), 32'(vecs[i].cs));
      chk($sformatf("vec%0d_dir", i), 32'(dir_w), 32'(vecs[i].d));
      chk($sformatf("vec%0d_run", i), 32'(run_w), 32'(vecs[i].r));
      chk($sformatf("vec%0d_tick", i), 32'(tick_w), 32'(vecs[i].t));
      chk($sformatf("vec%0d_limit_wrap", i), 32'(limit_w), 32'(vecs[i].lw));
      chk($sformatf("vec%0d_limit_sat", i), 32'(limit_s), 32'(vecs[i].ls));
    end
    btn_dir = 1'b0; btn_run = 1'b0; btn_clr = 1'b0;

    // Held dir button: one toggle only, at the third edge after first sample
    do_reset();
    btn_dir = 1'b1;
    cyc(); cyc();
    chk("hold_dir_before", 32'(dir_w), 32'd0);
    cyc();
    chk("hold_dir_toggle", 32'(dir_w), 32'd1);
    repeat (7) cyc();
    btn_dir = 1'b0;
    repeat (3) cyc();
    chk("hold_dir_once", 32'(dir_w), 32'd1);

    // Clear coincident with a step at count 9 (wrap counting down)
    do_reset();
    repeat (29) cyc();
    btn_clr = 1'b1;
    cyc(); cyc();
    btn_clr = 1'b0;
    chk("clr_pre_count", 32'(count_w), 32'd9);
    cyc();
    chk("clr_count", 32'(count_w), 32'd0);
    chk("clr_no_tick", 32'(tick_w), 32'd0);
    repeat (3) cyc();
    chk("clr_quiet", 32'(tick_w), 32'd0);
    cyc();
    chk("clr_next_tick", 32'(tick_w), 32'd1);
    chk("clr_next_count", 32'(count_w), 32'd15);
    chk("clr_next_limit", 32'(limit_w), 32'd1);
    chk("clr_sat_limit", 32'(limit_s), 32'd1);

    // Saturation at max, then a dir press steps back down without limit
    do_reset();
    btn_dir = 1'b1;
    cyc();
    btn_dir = 1'b0;
    repeat (59) cyc();
    chk("sat_reach_max", 32'(count_s), 32'd15);
    repeat (4) cyc();
    chk("sat_hold_count", 32'(count_s), 32'd15);
    chk("sat_hold_limit", 32'(limit_s), 32'd1);
    chk("sat_hold_tick", 32'(tick_s), 32'd1);
    chk("wrap_up_limit", 32'(limit_w), 32'd1);
    chk("wrap_up_count", 32'(count_w), 32'd0);
    btn_dir = 1'b1;
    cyc();
    btn_dir = 1'b0;
    repeat (3) cyc();
    chk("sat_back_count", 32'(count_s), 32'd14);
    chk("sat_back_limit", 32'(limit_s), 32'd0);
    chk("wrap_down_count", 32'(count_w), 32'd15);
    chk("wrap_down_limit", 32'(limit_w), 32'd1);

    // Button held through reset yields a fresh press afterwards
    btn_run = 1'b1;
    do_reset();
    cyc(); cyc();
    chk("rst_hold_run_before", 32'(run_w), 32'd1);
    cyc();
    chk("rst_hold_run_toggle", 32'(run_w), 32'd0);
    btn_run = 1'b0;

    // Random buttons and occasional reset against the model
    repeat (3000) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) btn_dir = ~btn_dir;
      if ($urandom_range(0, 9) == 0) btn_run = ~btn_run;
      if ($urandom_range(0, 15) == 0) btn_clr = ~btn_clr;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
